// File: rtl/sm4_axis8_unpad.sv
// PKCS#7 unpadder for a decrypted SM4 byte stream; 17-byte hold-back, 1-cycle registered output.
// Backpressure: s_axis_tready drops only while draining a frame. SM4_UNPAD_STRICT_CHECK_EN = full pad-byte check.
module sm4_axis8_unpad (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic [7:0] s_axis_tuser,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tuser,
  output logic       pad_err,
  output logic       pad_empty
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2, FLUSH = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_q [17];   // {tuser, tdata}; newest at index 0
  logic [4:0]  cnt, cnt_nxt, rem, rem_nxt, held, rem_last;
  logic [13:0] len, len_nxt, len_inc;
  logic        err_q, err_nxt;
  logic        accept, shift, len_ok, p_ok, bytes_ok, pad_good;
  logic        o_vld, o_last, o_err, o_empty;
  logic [15:0] oldest;

  assign s_axis_tready = (state != FLUSH);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign len_inc       = (len == 14'h3fff) ? len : len + 14'd1;
  assign len_ok        = (len_inc[3:0] == 4'd0) && (len_inc >= 14'd16);
  assign p_ok          = (s_axis_tdata >= 8'd1) && (s_axis_tdata <= 8'd16);
  assign pad_good      = len_ok & p_ok & bytes_ok;
  // Bytes still owed from t+1 once tlast is taken, counting the incoming byte.
  assign held          = cnt + 5'd1;
  assign rem_last      = pad_good ? held - s_axis_tdata[4:0] : held;
  assign oldest        = (cnt == 5'd0) ? {s_axis_tuser, s_axis_tdata} : hold_q[cnt - 5'd1];

`ifdef SM4_UNPAD_STRICT_CHECK_EN
  always_comb begin
    bytes_ok = 1'b1;
    for (int i = 1; i < 16; i++) begin
      if ((8'(i) < s_axis_tdata) && (hold_q[i-1][7:0] != s_axis_tdata)) bytes_ok = 1'b0;
    end
  end
`else
  assign bytes_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    len_nxt   = len;
    err_nxt   = err_q;
    shift     = 1'b0;
    o_vld     = 1'b0;
    o_last    = 1'b0;
    o_err     = 1'b0;
    o_empty   = 1'b0;
    case (state)
      IDLE, FILL, STREAM: begin
        if (accept) begin
          shift   = 1'b1;
          len_nxt = len_inc;
          if (s_axis_tlast) begin
            if (rem_last == 5'd0) begin
              o_empty   = 1'b1;
              state_nxt = IDLE;
              cnt_nxt   = 5'd0;
              len_nxt   = 14'd0;
            end else if (rem_last == 5'd1) begin
              o_vld     = 1'b1;
              o_last    = 1'b1;
              o_err     = ~pad_good;
              state_nxt = IDLE;
              cnt_nxt   = 5'd0;
              len_nxt   = 14'd0;
            end else begin
              // Oldest byte leaves now, incoming byte takes its slot: cnt unchanged.
              o_vld     = 1'b1;
              err_nxt   = ~pad_good;
              rem_nxt   = rem_last - 5'd1;
              state_nxt = FLUSH;
            end
          end else if (state == STREAM) begin
            o_vld = 1'b1;
          end else begin
            cnt_nxt   = cnt + 5'd1;
            state_nxt = (cnt == 5'd16) ? STREAM : FILL;
          end
        end
      end
      FLUSH: begin
        o_vld   = 1'b1;
        cnt_nxt = cnt - 5'd1;
        rem_nxt = rem - 5'd1;
        if (rem == 5'd1) begin
          o_last    = 1'b1;
          o_err     = err_q;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
          len_nxt   = 14'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 5'd0;
      rem           <= 5'd0;
      len           <= 14'd0;
      err_q         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tuser  <= 8'd0;
      pad_err       <= 1'b0;
      pad_empty     <= 1'b0;
      for (int i = 0; i < 17; i++) hold_q[i] <= 16'd0;
    end else begin
      cnt           <= cnt_nxt;
      rem           <= rem_nxt;
      len           <= len_nxt;
      err_q         <= err_nxt;
      m_axis_tvalid <= o_vld;
      m_axis_tlast  <= o_last;
      m_axis_tdata  <= o_vld ? oldest[7:0] : 8'd0;
      m_axis_tuser  <= o_vld ? oldest[15:8] : 8'd0;
      pad_err       <= o_err;
      pad_empty     <= o_empty;
      if (shift) begin
        hold_q[0] <= {s_axis_tuser, s_axis_tdata};
        for (int i = 1; i < 17; i++) hold_q[i] <= hold_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sm4_axis8_unpad.sv
// Directed bench for sm4_axis8_unpad: frame table plus reset and back-to-back sequences.
module tb_sm4_axis8_unpad;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata, s_axis_tuser, m_axis_tdata, m_axis_tuser;
  logic       s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic       m_axis_tvalid, m_axis_tlast, pad_err, pad_empty;

  sm4_axis8_unpad dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .pad_err(pad_err), .pad_empty(pad_empty)
  );

  always #5 clk = ~clk;

`ifdef SM4_UNPAD_STRICT_CHECK_EN
  localparam int STRICT = 1;
`else
  localparam int STRICT = 0;
`endif

  typedef struct {
    int         len;
    int         tail_n;
    logic [7:0] tail_val;
    int         odd_idx;
    logic [7:0] odd_val;
    int         exp_n;
    int         exp_err;
    int         exp_empty;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] fr_d [128];
  logic [7:0] fr_u [128];
  logic [7:0] got_d [$];
  logic [7:0] got_u [$];
  logic       got_l [$];
  int err_cnt = 0, empty_cnt = 0, stray = 0, rdy_low = 0, last_out_cyc = 0, empty_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      got_d.push_back(m_axis_tdata);
      got_u.push_back(m_axis_tuser);
      got_l.push_back(m_axis_tlast);
      if (m_axis_tlast) last_out_cyc = cyc;
    end else if (m_axis_tdata != 8'd0 || m_axis_tuser != 8'd0 || m_axis_tlast) begin
      stray++;
    end
    if (pad_err) begin
      err_cnt++;
      if (!(m_axis_tvalid && m_axis_tlast)) stray++;
    end
    if (pad_empty) begin
      empty_cnt++;
      empty_cyc = cyc;
    end
    if (!s_axis_tready) rdy_low++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(input vec_t v, input int tag, input int off);
    for (int i = 0; i < v.len; i++) begin
      fr_d[off+i] = 8'(i);
      if (i >= v.len - v.tail_n) fr_d[off+i] = v.tail_val;
      if (i == v.odd_idx) fr_d[off+i] = v.odd_val;
      fr_u[off+i] = 8'(i * 7 + tag * 13 + 1);
    end
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'd0;
    s_axis_tuser  = 8'd0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send(input int off, input int n, input logic do_last, output int t_acc);
    int w;
    t_acc = 0;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fr_d[off+i];
      s_axis_tuser  = fr_u[off+i];
      s_axis_tlast  = do_last && (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (w >= 100) chk("tready_timeout", 0, 1);
      t_acc = cyc;
      @(posedge clk);
      #1;
    end
    s_axis_tlast = 1'b0;
  endtask

  // Compare n0 expected bytes of fr[off..] against the capture starting at base.
  task automatic cmp_bytes(input string nm, input int base, input int off, input int n0,
                           output int mism, output int nl);
    mism = 0;
    nl   = 0;
    for (int i = 0; i < n0; i++) begin
      if (base + i < got_d.size()) begin
        if (got_d[base+i] != fr_d[off+i] || got_u[base+i] != fr_u[off+i]) begin
          mism++;
          if (mism == 1)
            $display("  %s byte %0d: data %02h user %02h vs %02h %02h", nm, i,
                     got_d[base+i], got_u[base+i], fr_d[off+i], fr_u[off+i]);
        end
        if (got_l[base+i]) begin
          nl++;
          if (i != n0 - 1) mism++;
        end
      end
    end
  endtask

  initial begin
    int t, t2, base, e0, m0, s0, r0, n, mism, nl, mism2, nl2, prior;
    vt[0]  = '{32,  4, 8'h04, -1, 8'h00, 28, 0, 0};
    vt[1]  = '{16, 16, 8'h10, -1, 8'h00,  0, 0, 1};
    vt[2]  = '{20,  1, 8'h04, -1, 8'h00, 20, 1, 0};
    vt[3]  = '{32,  1, 8'h00, -1, 8'h00, 32, 1, 0};
    vt[4]  = '{32,  1, 8'h11, -1, 8'h00, 32, 1, 0};
    vt[5]  = '{32,  3, 8'h03, 29, 8'h07, (STRICT != 0) ? 32 : 29, STRICT, 0};
    vt[6]  = '{ 1,  1, 8'h01, -1, 8'h00,  1, 1, 0};
    vt[7]  = '{16,  1, 8'h01, -1, 8'h00, 15, 0, 0};
    vt[8]  = '{48, 16, 8'h10, -1, 8'h00, 32, 0, 0};
    vt[9]  = '{16,  1, 8'h11, -1, 8'h00, 16, 1, 0};
    vt[10] = '{17,  1, 8'h01, -1, 8'h00, 17, 1, 0};
    vt[11] = '{32, 16, 8'h10, -1, 8'h00, 16, 0, 0};

    // Reset: tready high, outputs quiet, a beat offered during reset must not be consumed.
    rst = 1'b1;
    idle();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h55;
    s_axis_tuser  = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", int'(s_axis_tready), 1);
    chk("rst_outputs", int'({m_axis_tvalid, m_axis_tlast, pad_err, pad_empty, m_axis_tdata, m_axis_tuser}), 0);
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      build(vt[k], k, 0);
      base = got_d.size(); e0 = err_cnt; m0 = empty_cnt; s0 = stray;
      send(0, vt[k].len, 1'b1, t);
      idle();
      repeat (30) @(posedge clk);
      #1;
      n = got_d.size() - base;
      chk($sformatf("v%0d_count", k), n, vt[k].exp_n);
      cmp_bytes($sformatf("v%0d", k), base, 0, vt[k].exp_n, mism, nl);
      chk($sformatf("v%0d_bytes", k), mism, 0);
      chk($sformatf("v%0d_tlast", k), nl, (vt[k].exp_n > 0) ? 1 : 0);
      chk($sformatf("v%0d_pad_err", k), err_cnt - e0, vt[k].exp_err);
      chk($sformatf("v%0d_pad_empty", k), empty_cnt - m0, vt[k].exp_empty);
      chk($sformatf("v%0d_stray", k), stray - s0, 0);
      prior = (vt[k].len > 18) ? vt[k].len - 18 : 0;
      if (vt[k].exp_empty != 0) chk($sformatf("v%0d_empty_lat", k), empty_cyc - t, 1);
      else chk($sformatf("v%0d_last_lat", k), last_out_cyc - t, vt[k].exp_n - prior);
    end

    // Two 48-byte frames with tvalid held high: tready low for 13 FLUSH cycles each.
    build('{48, 4, 8'h04, -1, 8'h00, 44, 0, 0}, 20, 0);
    build('{48, 4, 8'h04, -1, 8'h00, 44, 0, 0}, 21, 64);
    base = got_d.size(); e0 = err_cnt; r0 = rdy_low; s0 = stray;
    send(0, 48, 1'b1, t);
    send(64, 48, 1'b1, t2);
    idle();
    repeat (30) @(posedge clk);
    #1;
    chk("b2b_count", got_d.size() - base, 88);
    cmp_bytes("b2b_f1", base, 0, 44, mism, nl);
    cmp_bytes("b2b_f2", base + 44, 64, 44, mism2, nl2);
    chk("b2b_f1_bytes", mism, 0);
    chk("b2b_f2_bytes", mism2, 0);
    chk("b2b_tlast", nl + nl2, 2);
    chk("b2b_tready_low", rdy_low - r0, 26);
    chk("b2b_gap", t2 - t, 14 + 47);
    chk("b2b_pad_err", err_cnt - e0, 0);
    chk("b2b_stray", stray - s0, 0);

    // Reset after 20 beats: 3 bytes already streamed, no tlast or pulses, then a clean P=1 frame.
    build('{20, 0, 8'h00, -1, 8'h00, 0, 0, 0}, 30, 0);
    base = got_d.size(); e0 = err_cnt; m0 = empty_cnt;
    send(0, 20, 1'b0, t);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n = got_d.size() - base;
    cmp_bytes("rst_partial", base, 0, n, mism, nl);
    chk("rst_partial_count", n, 3);
    chk("rst_partial_tlast", nl, 0);
    chk("rst_partial_pulses", (err_cnt - e0) + (empty_cnt - m0), 0);
    build('{16, 1, 8'h01, -1, 8'h00, 15, 0, 0}, 31, 0);
    base = got_d.size(); e0 = err_cnt;
    send(0, 16, 1'b1, t);
    idle();
    repeat (25) @(posedge clk);
    #1;
    chk("rst_next_count", got_d.size() - base, 15);
    cmp_bytes("rst_next", base, 0, 15, mism, nl);
    chk("rst_next_bytes", mism, 0);
    chk("rst_next_tlast", nl, 1);
    chk("rst_next_pad_err", err_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm4_axis8_unpad.md
SM4_AXIS8_UNPAD -- requirements
Module: sm4_axis8_unpad

Interface
REQ-001 SHALL have no parameters; buffer depth fixed at 17 bytes, frame counter 14 bits.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 s_axis_tdata  in  8  decrypted plaintext byte, PKCS#7-padded to 16-byte multiple.
REQ-005 s_axis_tvalid  in  1 / s_axis_tlast  in  1 / s_axis_tuser  in  8  per-byte sideband.
REQ-006 s_axis_tready  out  1  input accepted when tvalid&tready.
REQ-007 m_axis_tdata  out  8 / m_axis_tvalid  out  1 / m_axis_tlast  out  1 / m_axis_tuser  out  8  (no m_axis_tready; sink always accepts).
REQ-008 pad_err  out  1  one-cycle pulse on bad padding; pad_empty  out  1  one-cycle pulse when stripped frame is empty.

Function
REQ-009 States: IDLE (no bytes held), FILL (1..16 held), STREAM (17 held), FLUSH (tlast received, draining).
REQ-010 s_axis_tready = 1 in IDLE/FILL/STREAM, 0 in FLUSH; combinational from state.
REQ-011 Accepted beat in IDLE/FILL: byte+tuser appended, no output; IDLE->FILL on first beat, FILL->STREAM when occupancy reaches 17.
REQ-012 Accepted non-last beat in STREAM: oldest byte+tuser on m_axis next cycle with tvalid=1, tlast=0; new byte appended.
REQ-013 All m_axis outputs registered; tvalid high exactly one cycle per emitted byte; tdata/tuser/tlast 0 when tvalid=0.
REQ-014 Frame length L counted per accepted beat (saturating at 16383); P = tdata of tlast beat.
REQ-015 Padding valid iff L[3:0]==0, L>=16, 1<=P<=16 (plus REQ-027 when enabled).
REQ-016 Valid: total frame output exactly L-P bytes in order; bytes remaining at tlast acceptance (cycle t) emitted on consecutive cycles from t+1; m_axis_tlast on byte L-P.
REQ-017 Valid with L-P==0 (L=16,P=16): no byte emitted, pad_empty pulses at t+1.
REQ-018 Invalid: all L bytes emitted unmodified, consecutive from t+1, tlast on byte L; pad_err pulses coincident with that tlast.
REQ-019 Single-byte frame (tlast on first beat): invalid, byte emitted with tlast at t+1, pad_err.
REQ-020 FLUSH->IDLE in the cycle the final byte is on m_axis (or at t+1 for empty); s_axis_tready=1 that cycle; new frame's first beat accepted then.
REQ-021 tvalid while tready=0 ignored; upstream holds the beat.
REQ-022 L counter and buffer cleared on entry to IDLE; frames are independent.

Reset
REQ-023 While rst=1: state IDLE, buffer and L cleared, all m_axis outputs, pad_err, pad_empty = 0; input ignored.
REQ-024 rst mid-frame or mid-FLUSH: held bytes discarded, no tlast emitted, no pulses; first beat accepted cycle after rst deasserts.
REQ-025 s_axis_tready reads 1 during reset (state IDLE); beats presented then are not consumed.

Configuration
REQ-026 Macro SM4_UNPAD_STRICT_CHECK_EN selects padding check depth.
REQ-027 Defined: padding valid only if additionally all last P bytes equal P (full PKCS#7); mismatch -> REQ-018 path.
REQ-028 Undefined: only last byte P checked; pad byte contents ignored; timing identical either way.

Verification
REQ-029 32-byte frame, bytes 0x00..0x1B then 4x 0x04 -> 28 bytes 0x00..0x1B out, tlast on 0x1B, pad_err=0.
REQ-030 16-byte frame all 0x10 -> no m_axis_tvalid, pad_empty pulse at t+1.
REQ-031 20-byte frame ending 0x04 -> 20 bytes unmodified, tlast on byte 20, pad_err pulse; same with 32-byte frame ending 0x00 or 0x11.
REQ-032 32-byte frame ending 03 03 03 but byte 30 = 0x07: with macro -> 32 bytes out, pad_err; without -> 29 bytes out, no pad_err.
REQ-033 Back-to-back 48-byte frames, tvalid held high -> tready low only during FLUSH, second frame output intact, tuser preserved per byte.
REQ-034 rst asserted after 20 beats of a frame, then 16-byte valid frame (P=1) -> only 15 bytes of second frame out, tlast on 15th.
